// File: rtl/max_red_pkg.sv
// Shared definitions for the pipelined argmax tree: tie rule, width helpers and the
// reference node record used when documenting the tree.
package max_red_pkg;

    // Equal values resolve to the lower-index (left) child.
    localparam bit TIE_LOW_IDX = 1'b1;

    // Widths of the default 16-lane, 5-bit configuration.
    localparam int unsigned DEF_DATA_W = 5;
    localparam int unsigned DEF_IDX_W  = 4;

    // Field order matches the packed node vectors used by max_red_node.
    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] value;
        logic [DEF_IDX_W-1:0]  idx;
    } node_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned node_w(input int unsigned data_w, input int unsigned idx_w);
        return 1 + data_w + idx_w;
    endfunction

endpackage

// File: rtl/max_red_node.sv
// Combinational compare-select of two argmax nodes; left input covers the lower lanes.
module max_red_node
    import max_red_pkg::*;
#(
    parameter int unsigned DATA_W = 5,
    parameter int unsigned IDX_W  = 4,
    localparam int unsigned NODE_W = 1 + DATA_W + IDX_W
) (
    input  logic [NODE_W-1:0] a,
    input  logic [NODE_W-1:0] b,
    output logic [NODE_W-1:0] y
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] value;
        logic [IDX_W-1:0]  idx;
    } lnode_t;

    lnode_t na;
    lnode_t nb;
    lnode_t ny;
    logic   pick_a;
    logic   a_wins;

    assign na = a;
    assign nb = b;

    always_comb begin
        a_wins = TIE_LOW_IDX ? (na.value >= nb.value) : (na.value > nb.value);
        pick_a = na.valid && (!nb.valid || a_wins);
        ny       = pick_a ? na : nb;
        ny.valid = na.valid | nb.valid;
        if (!ny.valid) begin
            ny.value = '0;
            ny.idx   = '0;
        end
    end

    assign y = ny;

endmodule

// File: rtl/max_reduction_pipe.sv
// Pipelined argmax tree: one register level per tree level, global stall enable.
// Optional sideband tag carried with each beat when MAX_RED_TAG_EN is defined.
module max_reduction_pipe
    import max_red_pkg::*;
#(
    parameter int unsigned N_IN   = 16,
    parameter int unsigned DATA_W = 5,
    parameter int unsigned IDX_W  = clog2(N_IN),
    parameter int unsigned TAG_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN-1:0]        in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_max,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_any
`ifdef MAX_RED_TAG_EN
    ,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [TAG_W-1:0]       out_tag
`endif
);

    localparam int unsigned L      = clog2(N_IN);
    localparam int unsigned NODE_W = node_w(DATA_W, IDX_W);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] value;
        logic [IDX_W-1:0]  idx;
    } lnode_t;

    if (N_IN < 2 || N_IN > 64 || (N_IN & (N_IN - 1)) != 0 || IDX_W != clog2(N_IN)
        || TAG_W == 0) begin : g_bad_cfg
        $error("max_reduction_pipe: unsupported parameter combination");
    end

    logic          en;
    logic          accept;
    logic [L-1:0]  vld_q;
    lnode_t        root;

    // Heap layout: node j has children 2j and 2j+1; node 1 is the root register.
    logic [NODE_W-1:0] leaf   [N_IN];
    logic [NODE_W-1:0] node_d [1:N_IN-1];
    logic [NODE_W-1:0] node_q [1:N_IN-1];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Bubbles enter as all-zero leaves so idle stages never carry stale data.
    for (genvar i = 0; i < N_IN; i++) begin : g_leaf
        lnode_t lf;
        always_comb begin
            lf = '0;
            if (accept && in_mask[i]) begin
                lf.valid = 1'b1;
                lf.value = in_data[i*DATA_W +: DATA_W];
                lf.idx   = IDX_W'(i);
            end
        end
        assign leaf[i] = lf;
    end

    for (genvar j = 1; j < N_IN; j++) begin : g_node
        logic [NODE_W-1:0] a;
        logic [NODE_W-1:0] b;
        if (2 * j >= N_IN) begin : g_from_leaf
            assign a = leaf[2*j - N_IN];
            assign b = leaf[2*j + 1 - N_IN];
        end else begin : g_from_reg
            assign a = node_q[2*j];
            assign b = node_q[2*j + 1];
        end
        max_red_node #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_node (
            .a (a),
            .b (b),
            .y (node_d[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 1; j < N_IN; j++) begin
                node_q[j] <= '0;
            end
            vld_q <= '0;
        end else if (en) begin
            for (int j = 1; j < N_IN; j++) begin
                node_q[j] <= node_d[j];
            end
            vld_q[0] <= accept;
            for (int k = 1; k < L; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign root      = node_q[1];
    assign out_valid = vld_q[L-1];
    assign out_max   = root.value;
    assign out_idx   = root.idx;
    assign out_any   = root.valid;

`ifdef MAX_RED_TAG_EN
    logic [TAG_W-1:0] tag_q [L];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                tag_q[k] <= '0;
            end
        end else if (en) begin
            tag_q[0] <= accept ? in_tag : '0;
            for (int k = 1; k < L; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign out_tag = tag_q[L-1];
`endif

endmodule

// File: tb/tb_max_reduction_pipe.sv
// Directed bench for max_reduction_pipe (16 lanes, 5-bit values); tag checks under MAX_RED_TAG_EN.
module tb_max_reduction_pipe;

    localparam int unsigned N_IN   = 16;
    localparam int unsigned DATA_W = 5;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned TAG_W  = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [N_IN*DATA_W-1:0] in_data = '0;
    logic [N_IN-1:0]        in_mask = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [DATA_W-1:0]      out_max;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_any;
    logic [TAG_W-1:0]       in_tag = '0;
`ifdef MAX_RED_TAG_EN
    logic [TAG_W-1:0]       out_tag;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] lanes [N_IN];

    max_reduction_pipe #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_any   (out_any)
`ifdef MAX_RED_TAG_EN
        ,
        .in_tag    (in_tag),
        .out_tag   (out_tag)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load();
        for (int i = 0; i < N_IN; i++) begin
            in_data[i*DATA_W +: DATA_W] = lanes[i];
        end
    endtask

    task automatic fill(input logic [DATA_W-1:0] v);
        for (int i = 0; i < N_IN; i++) begin
            lanes[i] = v;
        end
    endtask

    // Single beat with out_ready high: result must appear exactly 4 edges after acceptance.
    task automatic send_one(input string name, input logic [N_IN-1:0] mask,
                            input int exp_max, input int exp_idx, input int exp_any);
        @(negedge clk);
        in_valid = 1'b1;
        in_mask  = mask;
        load();
        #1;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_max"}, 32'(out_max), 32'(exp_max));
        check({name, "_idx"}, 32'(out_idx), 32'(exp_idx));
        check({name, "_any"}, 32'(out_any), 32'(exp_any));
    endtask

    int sent;
    int rcv;
    int extra;
    logic stall_prev;
    logic [DATA_W-1:0] held_max;
    logic [IDX_W-1:0]  held_idx;

    initial begin
        fill('0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_max", 32'(out_max), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_any", 32'(out_any), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Distinct values, max 30 at lane 3.
        lanes = '{5'd3, 5'd7, 5'd1, 5'd30, 5'd2, 5'd5, 5'd9, 5'd11,
                  5'd0, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14, 5'd16};
        send_one("distinct", 16'hFFFF, 30, 3, 1);

        // Tie between lanes 5 and 12.
        fill('0);
        lanes[5]  = 5'd31;
        lanes[12] = 5'd31;
        send_one("tie", 16'hFFFF, 31, 5, 1);

        // Largest lane masked off.
        fill(5'd1);
        lanes[2] = 5'd31;
        lanes[9] = 5'd20;
        send_one("mask", 16'hFFFB, 20, 9, 1);

        // All lanes masked.
        fill(5'd25);
        send_one("allmask", 16'h0000, 0, 0, 0);

        // Equal values, only upper ten lanes participate.
        fill(5'd17);
        send_one("eq_upper", 16'hFFC0, 17, 6, 1);

        // Back-to-back stream with out_ready pattern 1,0,0 repeating.
        sent       = 0;
        rcv        = 0;
        stall_prev = 1'b0;
        held_max   = '0;
        held_idx   = '0;
        in_mask    = 16'hFFFF;
        for (int c = 0; c < 300 && rcv < 10; c++) begin
            @(negedge clk);
            out_ready = (c % 3 == 0);
            if (sent < 10) begin
                in_valid = 1'b1;
                fill('0);
                lanes[(sent * 3) % 16] = DATA_W'(sent + 1);
                load();
                in_tag = TAG_W'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (stall_prev) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_max", 32'(out_max), 32'(held_max));
                check("bp_hold_idx", 32'(out_idx), 32'(held_idx));
            end
            if (out_valid && out_ready) begin
                check("bp_max", 32'(out_max), 32'(rcv + 1));
                check("bp_idx", 32'(out_idx), 32'((rcv * 3) % 16));
`ifdef MAX_RED_TAG_EN
                check("bp_tag", 32'(out_tag), 32'(rcv + 1));
`endif
                rcv++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            stall_prev = out_valid && !out_ready;
            held_max   = out_max;
            held_idx   = out_idx;
        end
        check("bp_received", 32'(rcv), 32'd10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        extra     = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        check("bp_no_dup", 32'(extra), 32'd0);

        // Reset with one result on the output and three beats in flight.
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            fill(5'd7);
            lanes[b] = DATA_W'(20 + b);
            load();
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rstmid_pre_valid", 32'(out_valid), 32'd1);
        check("rstmid_pre_max", 32'(out_max), 32'd20);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_max", 32'(out_max), 32'd0);
        check("rstmid_any", 32'(out_any), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        check("rstmid_no_stale", 32'(extra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
